// File: rtl/imem_responder.sv
// imem_responder: word-addressed instruction memory behind a single-request fetch handshake.
// A fetch accepted while ready is high returns one word WAIT_CYCLES+1 cycles later as a
// one-cycle inst_valid pulse. A loader port writes words independently of the fetch FSM.
// Optional feature: define IMEM_ADDR_CHECK_EN to fault misaligned or out-of-range fetches
// with inst_err=1 and an ebreak word; otherwise low address bits are ignored and the index wraps.
module imem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [63:0]              inst_addr,
  input  logic                     inst_ena,
  output logic [31:0]              inst,
  output logic                     inst_valid,
  output logic                     inst_err,
  output logic                     ready,
  input  logic                     load_ena,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [31:0] Ebreak   = 32'h0010_0073;
  localparam logic [3:0]  WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [63:0]   addr_q, addr_d;
  logic [31:0]   inst_q, inst_d;
  logic          err_q, err_d;
  logic          accept;
  logic          resp_load;
  logic [63:0]   rd_addr;
  logic [63:0]   rd_off;
  logic [AW-1:0] rd_idx;
  logic          rd_bad;

  logic [31:0] mem [DEPTH];

  assign ready  = (state_q != StWait);
  assign accept = inst_ena & ready;

  // With no wait states the word is read on the acceptance edge straight from the request
  // address; after a wait it is read from the latched address.
  assign rd_addr = (state_q == StWait) ? addr_q : inst_addr;
  assign rd_off  = rd_addr - BASE_ADDR;
  assign rd_idx  = rd_off[AW+1:2];

`ifdef IMEM_ADDR_CHECK_EN
  assign rd_bad = (rd_addr[1:0] != 2'b00) || (rd_addr < BASE_ADDR) ||
                  (rd_off >= (64'(DEPTH) << 2));
`else
  logic unused_off_bits;
  assign rd_bad          = 1'b0;
  assign unused_off_bits = ^{rd_off[63:AW+2], rd_off[1:0]};
`endif

  // Next-state logic for the fetch FSM and wait counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    resp_load = 1'b0;
    unique case (state_q)
      StIdle, StResp: begin
        if (accept) begin
          addr_d = inst_addr;
          if (WAIT_CYCLES == 0) begin
            state_d   = StResp;
            resp_load = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        // Requests arriving here are dropped: ready is low.
        if (cnt_q == 4'd0) begin
          state_d   = StResp;
          resp_load = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Response word capture; inst only moves when a response is produced.
  always_comb begin
    inst_d = inst_q;
    err_d  = err_q;
    if (resp_load) begin
      inst_d = rd_bad ? Ebreak : mem[rd_idx];
      err_d  = rd_bad;
    end
  end

  // FSM, counter, latched address and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 64'd0;
      inst_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end

  // Loader write port; not reset so contents survive rst. Read-first falls out of the
  // non-blocking write landing after the same-edge read capture.
  always_ff @(posedge clk) begin
    if (load_ena) begin
      mem[load_addr] <= load_data;
    end
  end

  assign inst       = inst_q;
  assign inst_valid = (state_q == StResp);
  assign inst_err   = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (WAIT_CYCLES 0, 3, 5) sharing clock, reset,
// address and loader; each has its own fetch strobe and a scoreboard queue of expected
// responses with their due cycle.
module tb_imem_responder;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [63:0]   inst_addr;
  logic          load_ena;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          ena    [3];
  logic [31:0]   inst_w [3];
  logic          vld    [3];
  logic          err    [3];
  logic          rdy    [3];

  typedef struct {logic [31:0] data; logic err; int due;} exp_t;
  typedef struct {logic [63:0] addr; logic [31:0] data; logic err;} vec_t;

  exp_t        q [3][$];
  logic [31:0] last [3];
  vec_t        vec [9];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;

  imem_responder #(.DEPTH(1024), .BASE_ADDR(64'h8000_0000), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_ena(ena[0]), .inst(inst_w[0]),
    .inst_valid(vld[0]), .inst_err(err[0]), .ready(rdy[0]), .load_ena(load_ena),
    .load_addr(load_addr), .load_data(load_data));

  imem_responder #(.DEPTH(1024), .BASE_ADDR(64'h8000_0000), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_ena(ena[1]), .inst(inst_w[1]),
    .inst_valid(vld[1]), .inst_err(err[1]), .ready(rdy[1]), .load_ena(load_ena),
    .load_addr(load_addr), .load_data(load_data));

  imem_responder #(.DEPTH(1024), .BASE_ADDR(64'h8000_0000), .WAIT_CYCLES(5)) u_dut5 (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_ena(ena[2]), .inst(inst_w[2]),
    .inst_valid(vld[2]), .inst_err(err[2]), .ready(rdy[2]), .load_ena(load_ena),
    .load_addr(load_addr), .load_data(load_data));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // Response monitor: pop and compare on every valid pulse; check inst holds otherwise.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (vld[d]) begin
        if (q[d].size() == 0) begin
          check($sformatf("unexpected_valid%0d", d), 64'(vld[d]), 64'd0);
        end else begin
          e = q[d].pop_front();
          check($sformatf("inst%0d", d), 64'(inst_w[d]), 64'(e.data));
          check($sformatf("err%0d", d), 64'(err[d]), 64'(e.err));
          check($sformatf("latency%0d", d), 64'(cyc), 64'(e.due));
        end
      end else if (!rst) begin
        check($sformatf("hold%0d", d), 64'(inst_w[d]), 64'(last[d]));
      end
      last[d] = inst_w[d];
    end
  end

  task automatic drain(input int d);
    for (int n = 0; n < 40 && q[d].size() != 0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    check($sformatf("drain%0d", d), 64'(q[d].size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      ena[d]  = 1'b0;
      last[d] = 32'd0;
    end
    inst_addr = 64'd0;
    load_ena  = 1'b0;
    load_addr = '0;
    load_data = 32'd0;
    #1 rst = 1'b1;

    // Preload while in reset: word i = 0x93 | i<<12, word 1023 = DEADBEEF.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      load_ena  = 1'b1;
      load_addr = AW'(i);
      load_data = 32'h93 | (32'(i) << 12);
    end
    @(posedge clk); #2;
    load_addr = '1;
    load_data = 32'hDEAD_BEEF;
    @(posedge clk); #2;
    load_ena = 1'b0;

    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_inst%0d", d), 64'(inst_w[d]), 64'd0);
      check($sformatf("rst_valid%0d", d), 64'(vld[d]), 64'd0);
      check($sformatf("rst_err%0d", d), 64'(err[d]), 64'd0);
      check($sformatf("rst_ready%0d", d), 64'(rdy[d]), 64'd1);
    end
    @(posedge clk); #2;
    rst = 1'b0;

    // Back-to-back fetches on the zero-wait instance.
    vec[0] = '{64'h8000_0000, 32'h0000_0093, 1'b0};
    vec[1] = '{64'h8000_0004, 32'h0000_1093, 1'b0};
    vec[2] = '{64'h8000_0008, 32'h0000_2093, 1'b0};
    vec[3] = '{64'h8000_000C, 32'h0000_3093, 1'b0};
    vec[4] = '{64'h8000_0010, 32'h0000_4093, 1'b0};
    vec[5] = '{64'h8000_0FFC, 32'hDEAD_BEEF, 1'b0};
`ifdef IMEM_ADDR_CHECK_EN
    vec[6] = '{64'h8000_1000, 32'h0010_0073, 1'b1};
    vec[7] = '{64'h8000_0002, 32'h0010_0073, 1'b1};
    vec[8] = '{64'h7FFF_FFFC, 32'h0010_0073, 1'b1};
`else
    vec[6] = '{64'h8000_1000, 32'h0000_0093, 1'b0};
    vec[7] = '{64'h8000_0006, 32'h0000_1093, 1'b0};
    vec[8] = '{64'h7FFF_FFFC, 32'hDEAD_BEEF, 1'b0};
`endif
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #2;
      check("ready0_b2b", 64'(rdy[0]), 64'd1);
      ena[0]    = 1'b1;
      inst_addr = vec[i].addr;
      q[0].push_back('{vec[i].data, vec[i].err, cyc + 1});
    end
    @(posedge clk); #2;
    ena[0] = 1'b0;
    drain(0);

    // Three wait states; a second request during WAIT must be dropped.
    @(posedge clk); #2;
    ena[1]    = 1'b1;
    inst_addr = 64'h8000_0004;
    q[1].push_back('{32'h0000_1093, 1'b0, cyc + 4});
    @(posedge clk); #2;
    ena[1] = 1'b0;
    check("ready3_w0", 64'(rdy[1]), 64'd0);
    @(posedge clk); #2;
    check("ready3_w1", 64'(rdy[1]), 64'd0);
    ena[1]    = 1'b1;
    inst_addr = 64'h8000_0008;
    @(posedge clk); #2;
    check("ready3_w2", 64'(rdy[1]), 64'd0);
    ena[1] = 1'b0;
    @(posedge clk); #2;
    check("ready3_resp", 64'(rdy[1]), 64'd1);
    repeat (8) @(posedge clk);
    drain(1);

    // Read-first: load word 1 on the same edge that reads it.
    @(posedge clk); #2;
    ena[0]    = 1'b1;
    inst_addr = 64'h8000_0004;
    load_ena  = 1'b1;
    load_addr = AW'(1);
    load_data = 32'hAAAA_AAAA;
    q[0].push_back('{32'h0000_1093, 1'b0, cyc + 1});
    @(posedge clk); #2;
    load_ena = 1'b0;
    q[0].push_back('{32'hAAAA_AAAA, 1'b0, cyc + 1});
    @(posedge clk); #2;
    ena[0] = 1'b0;
    drain(0);

    // Five wait states: one full response, then reset two cycles into a second one.
    @(posedge clk); #2;
    ena[2]    = 1'b1;
    inst_addr = 64'h8000_0008;
    q[2].push_back('{32'h0000_2093, 1'b0, cyc + 6});
    @(posedge clk); #2;
    ena[2] = 1'b0;
    drain(2);
    @(posedge clk); #2;
    ena[2]    = 1'b1;
    inst_addr = 64'h8000_000C;
    @(posedge clk); #2;
    ena[2] = 1'b0;
    check("ready5_wait", 64'(rdy[2]), 64'd0);
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort_inst", 64'(inst_w[2]), 64'd0);
    check("abort_valid", 64'(vld[2]), 64'd0);
    check("abort_err", 64'(err[2]), 64'd0);
    check("abort_ready", 64'(rdy[2]), 64'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    check("post_abort_inst", 64'(inst_w[2]), 64'd0);
    check("post_abort_ready", 64'(rdy[2]), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
